load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter: WORD_ADDR, 0, 0 = mem_a is a word-aligned byte address; 1 = mem_a is the word index, i.e. addr >> 2 with the top two bits zero.
REQ-002 SHALL have ports: clk  in  1  single clock, rising edge.
REQ-003 SHALL have ports: rst  in  1  asynchronous active-low reset.
REQ-004 SHALL have ports: req_valid  in  1  pipeline request present.
REQ-005 SHALL have ports: req_ready  out  1  unit can accept a request.
REQ-006 SHALL have ports: req_we  in  1  1 = store, 0 = load.
REQ-007 SHALL have ports: req_funct3  in  3  RISC-V size/sign code (000 B, 001 H, 010 W, 100 BU, 101 HU).
REQ-008 SHALL have ports: req_addr  in  32  byte address.
REQ-009 SHALL have ports: req_wdata  in  32  store data, LSB-aligned.
REQ-010 SHALL have ports: rsp_valid  out  1  one-cycle completion pulse.
REQ-011 SHALL have ports: rsp_rdata  out  32  extended load data; 0 for stores and errors.
REQ-012 SHALL have ports: rsp_err  out  1  illegal or misaligned access, qualified by rsp_valid.
REQ-013 SHALL have ports: mem_a, mem_wd  out  32 each  data-memory address and write data.
REQ-014 SHALL have ports: mem_we, mem_re  out  1 each  data-memory write and read enable.
REQ-015 SHALL have ports: mem_rd  in  32  combinational data-memory read data; reads 0 whenever mem_we=1.

Function
REQ-016 SHALL implement FSM states IDLE, RD, WR, RESP; req_ready SHALL be 1 only in IDLE.
REQ-017 SHALL accept a request on a rising edge with req_valid=1 in IDLE, registering we, funct3, addr and wdata.
REQ-018 Transitions SHALL be: load IDLE->RD->RESP; word store IDLE->WR->RESP; byte/halfword store IDLE->RD->WR->RESP (read-modify-write); error IDLE->RESP.
REQ-019 In RD, the unit SHALL drive mem_re=1 and mem_a = the word address of the registered addr, and SHALL capture mem_rd at the closing edge.
REQ-020 In WR, the unit SHALL drive mem_we=1 and mem_a as in RD; mem_wd SHALL be wdata for word stores, or the captured word with the addressed byte/halfword lane replaced by wdata[7:0]/[15:0] (lane = addr[1:0]).
REQ-021 Outside RD/WR, mem_a, mem_wd, mem_we and mem_re SHALL be 0; mem_we and mem_re SHALL never both be 1.
REQ-022 In RESP, rsp_valid SHALL be 1 for exactly one cycle, then the FSM SHALL return to IDLE.
REQ-023 Latency from the accept edge to the rsp_valid cycle SHALL be 2 cycles for load and word store, 3 for sub-word store, 1 for error.
REQ-024 Load data SHALL be lane-selected by addr[1:0]; B/H SHALL sign-extend, BU/HU SHALL zero-extend, W SHALL pass through.
REQ-025 funct3 values 011, 110, 111, and BU/HU on a store, SHALL produce rsp_err=1 with no memory access.
REQ-026 rsp_rdata and rsp_err SHALL be 0 whenever rsp_valid=0.
REQ-027 Address arithmetic SHALL ignore overflow; address 0xFFFFFFFC SHALL be legal.

Reset
REQ-028 rst=0 SHALL immediately force IDLE and all outputs to 0 except req_ready, which SHALL be 1 while rst=1 in IDLE.
REQ-029 Reset during RD of an RMW SHALL abort the store with memory unmodified; no rsp_valid SHALL follow.

Configuration
REQ-030 With LSU_MISALIGN_TRAP_EN defined, a halfword access with addr[0]=1 or a word access with addr[1:0]!=0 SHALL take the error path (rsp_err=1, no memory access).
REQ-031 Without LSU_MISALIGN_TRAP_EN, misaligned low address bits SHALL be truncated to natural alignment (H: addr[0]=0, W: addr[1:0]=0) and the access SHALL proceed normally.

Verification
REQ-032 SW addr 0x100, wdata 0xDEADBEEF -> one WR cycle, mem_wd=0xDEADBEEF, rsp_valid 2 cycles after accept, rsp_err=0.
REQ-033 SB addr 0x101, wdata 0x000000AA over word 0x11223344 -> RD then WR, mem_wd=0x1122AA44.
REQ-034 LB addr 0x103 with word 0x80FFFFFF -> rsp_rdata=0xFFFFFF80; LBU at the same address -> 0x00000080.
REQ-035 LH addr 0x102 with word 0x8001ABCD -> rsp_rdata=0xFFFF8001; LHU at the same address -> 0x00008001.
REQ-036 LW addr 0x102: with macro -> rsp_err=1 after 1 cycle and mem_re never asserted; without macro -> word at 0x100 returned.
REQ-037 SH addr 0x200, rst=0 asserted during RD -> memory at 0x200 unchanged, no rsp_valid, req_ready=1 after release; funct3=011 -> rsp_err=1.

Source files
------------

// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - request, response and data-memory signals of the load/store unit
interface load_store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] mem_a;
    logic [31:0] mem_wd;
    logic        mem_we;
    logic        mem_re;
    logic [31:0] mem_rd;

    // Unit side: takes requests and read data, drives responses and memory strobes
    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rd,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_a, mem_wd, mem_we, mem_re
    );

    // Pipeline/memory side
    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rd,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_a, mem_wd, mem_we, mem_re
    );
endinterface

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - RV32 load/store unit with RMW sub-word stores; optional LSU_MISALIGN_TRAP_EN
module load_store_unit #(
    parameter bit WORD_ADDR = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    load_store_unit_if.slave   bus
);

    typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

    state_t      state, state_nx;
    logic        r_we;
    logic [2:0]  r_f3;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_word;
    logic        r_err;

    logic        acc_err;
    logic [31:0] acc_addr;
    logic [31:0] word_a;
    logic [31:0] merged;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;

    // Classify the incoming request: illegal codes, stores of unsigned sizes, and alignment handling
    always_comb begin
        acc_err = (bus.req_funct3 == 3'b011) || (bus.req_funct3 == 3'b110) ||
                  (bus.req_funct3 == 3'b111) || (bus.req_we && bus.req_funct3[2]);
`ifdef LSU_MISALIGN_TRAP_EN
        if ((bus.req_funct3[1:0] == 2'b01 && bus.req_addr[0]) ||
            (bus.req_funct3[1:0] == 2'b10 && bus.req_addr[1:0] != 2'b00))
            acc_err = 1'b1;
        acc_addr = bus.req_addr;
`else
        // Misaligned low bits are dropped so the access lands on its natural boundary
        case (bus.req_funct3[1:0])
            2'b01:   acc_addr = {bus.req_addr[31:1], 1'b0};
            2'b10:   acc_addr = {bus.req_addr[31:2], 2'b00};
            default: acc_addr = bus.req_addr;
        endcase
`endif
    end

    assign word_a = WORD_ADDR ? {2'b00, r_addr[31:2]} : {r_addr[31:2], 2'b00};

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    // Request capture on accept and read-data capture at the end of RD
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_we    <= 1'b0;
            r_f3    <= 3'b000;
            r_addr  <= 32'h0;
            r_wdata <= 32'h0;
            r_word  <= 32'h0;
            r_err   <= 1'b0;
        end else begin
            if (state == IDLE && bus.req_valid) begin
                r_we    <= bus.req_we;
                r_f3    <= bus.req_funct3;
                r_addr  <= acc_addr;
                r_wdata <= bus.req_wdata;
                r_err   <= acc_err;
            end
            if (state == RD) r_word <= bus.mem_rd;
        end
    end

    // Store data: whole word, or the captured word with one lane replaced
    always_comb begin
        merged = r_word;
        case (r_f3[1:0])
            2'b00: begin
                case (r_addr[1:0])
                    2'b00: merged[7:0]   = r_wdata[7:0];
                    2'b01: merged[15:8]  = r_wdata[7:0];
                    2'b10: merged[23:16] = r_wdata[7:0];
                    default: merged[31:24] = r_wdata[7:0];
                endcase
            end
            2'b01: begin
                if (r_addr[1]) merged[31:16] = r_wdata[15:0];
                else           merged[15:0]  = r_wdata[15:0];
            end
            default: merged = r_wdata;
        endcase
    end

    // Load data: lane select then sign or zero extension
    always_comb begin
        case (r_addr[1:0])
            2'b00:   ld_byte = r_word[7:0];
            2'b01:   ld_byte = r_word[15:8];
            2'b10:   ld_byte = r_word[23:16];
            default: ld_byte = r_word[31:24];
        endcase
        ld_half = r_addr[1] ? r_word[31:16] : r_word[15:0];
        case (r_f3)
            3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  ld_data = {24'h0, ld_byte};
            3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
            3'b101:  ld_data = {16'h0, ld_half};
            default: ld_data = r_word;
        endcase
    end

    // Next state and all outputs, decoded from the current state
    always_comb begin
        state_nx      = state;
        bus.req_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        bus.rsp_rdata = 32'h0;
        bus.rsp_err   = 1'b0;
        bus.mem_a     = 32'h0;
        bus.mem_wd    = 32'h0;
        bus.mem_we    = 1'b0;
        bus.mem_re    = 1'b0;
        case (state)
            IDLE: begin
                bus.req_ready = rst;
                if (bus.req_valid) begin
                    if (acc_err)                          state_nx = RESP;
                    else if (!bus.req_we)                 state_nx = RD;
                    else if (bus.req_funct3[1:0] == 2'b10) state_nx = WR;
                    else                                  state_nx = RD;
                end
            end
            RD: begin
                bus.mem_re = 1'b1;
                bus.mem_a  = word_a;
                state_nx   = r_we ? WR : RESP;
            end
            WR: begin
                bus.mem_we = 1'b1;
                bus.mem_a  = word_a;
                bus.mem_wd = merged;
                state_nx   = RESP;
            end
            default: begin
                bus.rsp_valid = 1'b1;
                bus.rsp_err   = r_err;
                bus.rsp_rdata = (r_err || r_we) ? 32'h0 : ld_data;
                state_nx      = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - vector table, reset-abort sequence and randomized model check of load_store_unit
module tb_load_store_unit;

    localparam bit WA = 1'b0;

    logic clk = 1'b0;
    logic rst = 1'b0;
    load_store_unit_if lsu_bus();

    load_store_unit #(.WORD_ADDR(WA)) dut (.clk(clk), .rst(rst), .bus(lsu_bus));

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [31:0] mem [0:255];
    logic        pl_en = 1'b0;
    logic [7:0]  pl_idx = 8'h0;
    logic [31:0] pl_data = 32'h0;
    logic [7:0]  mem_idx;
    logic [31:0] exp_mem_a = 32'h0;

    assign mem_idx = WA ? lsu_bus.mem_a[7:0] : lsu_bus.mem_a[9:2];
    assign lsu_bus.mem_rd = lsu_bus.mem_we ? 32'h0 : mem[mem_idx];

    always @(posedge clk) begin
        if (lsu_bus.mem_we)  mem[mem_idx] <= lsu_bus.mem_wd;
        else if (pl_en)      mem[pl_idx]  <= pl_data;
    end

    int rd_cnt = 0, wr_cnt = 0, both_cnt = 0, addr_bad = 0, idle_bad = 0;
    always @(negedge clk) begin
        if (lsu_bus.mem_re) rd_cnt <= rd_cnt + 1;
        if (lsu_bus.mem_we) wr_cnt <= wr_cnt + 1;
        if (lsu_bus.mem_we && lsu_bus.mem_re) both_cnt <= both_cnt + 1;
        if ((lsu_bus.mem_we || lsu_bus.mem_re) && lsu_bus.mem_a != exp_mem_a) addr_bad <= addr_bad + 1;
        if (!lsu_bus.rsp_valid && (lsu_bus.rsp_rdata != 32'h0 || lsu_bus.rsp_err)) idle_bad <= idle_bad + 1;
        if (!(lsu_bus.mem_we || lsu_bus.mem_re) && (lsu_bus.mem_a != 32'h0 || lsu_bus.mem_wd != 32'h0))
            idle_bad <= idle_bad + 1;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic preload(input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        pl_en = 1'b1; pl_idx = addr[9:2]; pl_data = data;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    task automatic run(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, output logic [31:0] rdata, output logic err,
                       output int lat, output int nrd, output int nwr, output logic pulse_ok);
        int rd0, wr0;
        @(negedge clk);
        lsu_bus.req_valid = 1'b1; lsu_bus.req_we = we; lsu_bus.req_funct3 = f3;
        lsu_bus.req_addr = addr; lsu_bus.req_wdata = wdata;
        exp_mem_a = WA ? {2'b00, addr[31:2]} : {addr[31:2], 2'b00};
        @(posedge clk);
        rd0 = rd_cnt; wr0 = wr_cnt;
        @(negedge clk);
        lsu_bus.req_valid = 1'b0;
        lat = 1;
        while (!lsu_bus.rsp_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        rdata = lsu_bus.rsp_rdata;
        err   = lsu_bus.rsp_err;
        if (!lsu_bus.rsp_valid) lat = -1;
        @(posedge clk);
        nrd = rd_cnt - rd0;
        nwr = wr_cnt - wr0;
        #1;
        pulse_ok = !lsu_bus.rsp_valid && lsu_bus.req_ready;
    endtask

    // Reference behaviour from the size/lane/extension rules, using plain arithmetic
    function automatic void model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                  input logic [31:0] wdata, input logic [31:0] old,
                                  output logic [31:0] rdata, output logic [31:0] nword,
                                  output logic err, output int lat, output int nrd, output int nwr);
        int size, nbits, lane;
        logic [63:0] mask, val, smask, sb;
        size = int'(f3[1:0]);
        rdata = 32'h0; nword = old;
        err = (size == 3) || (f3[2] && (we || size == 2));
`ifdef LSU_MISALIGN_TRAP_EN
        if ((size == 1 && addr[0]) || (size == 2 && addr[1:0] != 2'b00)) err = 1'b1;
`endif
        if (err) begin
            lat = 1; nrd = 0; nwr = 0;
            return;
        end
        nbits = 8 << size;
        lane  = (int'(addr[1:0]) >> size) << size;
        mask  = (64'd1 << nbits) - 64'd1;
        if (!we) begin
            val = ({32'h0, old} >> (8 * lane)) & mask;
            if (!f3[2] && size < 2) begin
                sb  = 64'd1 << (nbits - 1);
                val = (val ^ sb) - sb;
            end
            rdata = val[31:0];
            lat = 2; nrd = 1; nwr = 0;
        end else begin
            smask = mask << (8 * lane);
            val   = ({32'h0, old} & ~smask) | (({32'h0, wdata} & mask) << (8 * lane));
            nword = val[31:0];
            lat = (size == 2) ? 2 : 3;
            nrd = (size == 2) ? 0 : 1;
            nwr = 1;
        end
    endfunction

    typedef struct {
        string       name;
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] init;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
        logic [31:0] exp_word;
        int          exp_nrd;
        int          exp_nwr;
    } vec_t;

    vec_t vecs[$];

    initial begin
        logic [31:0] rdata, m_rdata, m_word, addr, wdata, init;
        logic        err, m_err, pulse_ok, we;
        logic [2:0]  f3;
        int          lat, nrd, nwr, m_lat, m_nrd, m_nwr, seen;

        lsu_bus.req_valid = 1'b0; lsu_bus.req_we = 1'b0; lsu_bus.req_funct3 = 3'b000;
        lsu_bus.req_addr = 32'h0; lsu_bus.req_wdata = 32'h0;

        vecs.push_back('{"sw_100",    1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0,        32'h0,        0, 2, 32'hDEADBEEF, 0, 1});
        vecs.push_back('{"sb_101",    1, 3'b000, 32'h101, 32'h000000AA, 32'h11223344, 32'h0,        0, 3, 32'h1122AA44, 1, 1});
        vecs.push_back('{"lb_103",    0, 3'b000, 32'h103, 32'h0,        32'h80FFFFFF, 32'hFFFFFF80, 0, 2, 32'h80FFFFFF, 1, 0});
        vecs.push_back('{"lbu_103",   0, 3'b100, 32'h103, 32'h0,        32'h80FFFFFF, 32'h00000080, 0, 2, 32'h80FFFFFF, 1, 0});
        vecs.push_back('{"lh_102",    0, 3'b001, 32'h102, 32'h0,        32'h8001ABCD, 32'hFFFF8001, 0, 2, 32'h8001ABCD, 1, 0});
        vecs.push_back('{"lhu_102",   0, 3'b101, 32'h102, 32'h0,        32'h8001ABCD, 32'h00008001, 0, 2, 32'h8001ABCD, 1, 0});
        vecs.push_back('{"f3_011",    0, 3'b011, 32'h100, 32'h0,        32'h13572468, 32'h0,        1, 1, 32'h13572468, 0, 0});
        vecs.push_back('{"sbu_store", 1, 3'b100, 32'h104, 32'h000000FF, 32'hA5A5A5A5, 32'h0,        1, 1, 32'hA5A5A5A5, 0, 0});
        vecs.push_back('{"lw_top",    0, 3'b010, 32'hFFFFFFFC, 32'h0,   32'h12345678, 32'h12345678, 0, 2, 32'h12345678, 1, 0});
        vecs.push_back('{"sh_202",    1, 3'b001, 32'h202, 32'hFFFFBEEF, 32'h11223344, 32'h0,        0, 3, 32'hBEEF3344, 1, 1});
`ifdef LSU_MISALIGN_TRAP_EN
        vecs.push_back('{"lw_102",    0, 3'b010, 32'h102, 32'h0,        32'hCAFEF00D, 32'h0,        1, 1, 32'hCAFEF00D, 0, 0});
        vecs.push_back('{"sh_203",    1, 3'b001, 32'h203, 32'h0000BEEF, 32'h11223344, 32'h0,        1, 1, 32'h11223344, 0, 0});
`else
        vecs.push_back('{"lw_102",    0, 3'b010, 32'h102, 32'h0,        32'hCAFEF00D, 32'hCAFEF00D, 0, 2, 32'hCAFEF00D, 1, 0});
        vecs.push_back('{"sh_203",    1, 3'b001, 32'h203, 32'h0000BEEF, 32'h11223344, 32'h0,        0, 3, 32'hBEEF3344, 1, 1});
`endif

        // Reset state
        #12;
        chk("reset_rsp_valid", {31'h0, lsu_bus.rsp_valid}, 32'h0);
        chk("reset_mem_en", {30'h0, lsu_bus.mem_we, lsu_bus.mem_re}, 32'h0);
        chk("reset_mem_a", lsu_bus.mem_a, 32'h0);
        chk("reset_rsp_rdata", lsu_bus.rsp_rdata, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("reset_release_ready", {31'h0, lsu_bus.req_ready}, 32'h1);

        // Directed vector table
        foreach (vecs[i]) begin
            preload(vecs[i].addr, vecs[i].init);
            run(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, rdata, err, lat, nrd, nwr, pulse_ok);
            chk({vecs[i].name, "_lat"},   lat,              vecs[i].exp_lat);
            chk({vecs[i].name, "_rdata"}, rdata,            vecs[i].exp_rdata);
            chk({vecs[i].name, "_err"},   {31'h0, err},     {31'h0, vecs[i].exp_err});
            chk({vecs[i].name, "_mem"},   mem[vecs[i].addr[9:2]], vecs[i].exp_word);
            chk({vecs[i].name, "_nrd"},   nrd,              vecs[i].exp_nrd);
            chk({vecs[i].name, "_nwr"},   nwr,              vecs[i].exp_nwr);
            chk({vecs[i].name, "_pulse"}, {31'h0, pulse_ok}, 32'h1);
        end

        // Reset asserted while a halfword RMW store sits in RD
        preload(32'h200, 32'h55667788);
        @(negedge clk);
        lsu_bus.req_valid = 1'b1; lsu_bus.req_we = 1'b1; lsu_bus.req_funct3 = 3'b001;
        lsu_bus.req_addr = 32'h200; lsu_bus.req_wdata = 32'h00001234;
        exp_mem_a = WA ? 32'h80 : 32'h200;
        @(posedge clk);
        @(negedge clk);
        lsu_bus.req_valid = 1'b0;
        chk("abort_in_rd", {31'h0, lsu_bus.mem_re}, 32'h1);
        #2 rst = 1'b0;
        #1;
        chk("abort_outs_cleared", {29'h0, lsu_bus.mem_re, lsu_bus.mem_we, lsu_bus.rsp_valid}, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (lsu_bus.rsp_valid) seen++;
        end
        chk("abort_no_rsp", seen, 0);
        chk("abort_mem_kept", mem[8'h80], 32'h55667788);
        chk("abort_ready", {31'h0, lsu_bus.req_ready}, 32'h1);

        // Randomized requests against the reference model
        for (int n = 0; n < 150; n++) begin
            we    = 1'($urandom_range(0, 1));
            f3    = 3'($urandom_range(0, 7));
            addr  = $urandom;
            if ($urandom_range(0, 3) != 0) addr = {22'h0, addr[9:0]};
            wdata = $urandom;
            init  = $urandom;
            preload(addr, init);
            model(we, f3, addr, wdata, init, m_rdata, m_word, m_err, m_lat, m_nrd, m_nwr);
            run(we, f3, addr, wdata, rdata, err, lat, nrd, nwr, pulse_ok);
            chk($sformatf("rnd%0d_lat", n),   lat,   m_lat);
            chk($sformatf("rnd%0d_rdata", n), rdata, m_rdata);
            chk($sformatf("rnd%0d_err", n),   {31'h0, err}, {31'h0, m_err});
            chk($sformatf("rnd%0d_mem", n),   mem[addr[9:2]], m_word);
            chk($sformatf("rnd%0d_nrd", n),   nrd,   m_nrd);
            chk($sformatf("rnd%0d_nwr", n),   nwr,   m_nwr);
        end

        @(negedge clk);
        chk("never_we_and_re", both_cnt, 0);
        chk("mem_a_word_addr", addr_bad, 0);
        chk("outputs_zero_when_idle", idle_bad, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
